// File: rtl/ristretto_imem_responder.sv
// rtl/ristretto_imem_responder.sv - instruction-memory responder for the IF fetch protocol
// Grants requests, reads a preloadable word array, returns in-order responses after ReadLatency cycles.
module ristretto_imem_responder #(
  parameter int MemWords       = 1024,
  parameter int ReadLatency    = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  input  logic                        load_we_i,
  input  logic [$clog2(MemWords)-1:0] load_addr_i,
  input  logic [31:0]                 load_wdata_i,
  output logic [1:0]                  state_o
);
  localparam int AW = $clog2(MemWords);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  typedef enum logic [1:0] {
    RSP_IDLE = 2'b00,
    RSP_BUSY = 2'b01,
    RSP_FULL = 2'b10
  } rsp_state_e;

  logic [31:0]            mem_q [MemWords];
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] err_q;
  logic [31:0]            data_q [ReadLatency];
  logic [CW-1:0]          cnt_q, cnt_d;
  rsp_state_e             state_q, state_d;

  logic          accept;
  logic          retire;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;

  // The slot count is the registered value, so a same-cycle retire cannot free a grant.
  assign instr_gnt_o = instr_req_i && !stall_i && (cnt_q < MaxCnt);
  assign accept      = instr_gnt_o;
  assign retire      = vld_q[ReadLatency-1];
  assign acc_idx     = instr_addr_i[2 +: AW];
  assign acc_err     = (instr_addr_i[1:0] != 2'b00) || (instr_addr_i[31:2] >= 30'(MemWords));
  // Reading mem_q before the edge gives read-before-write on a preload collision.
  assign acc_data    = (accept && !acc_err) ? mem_q[acc_idx] : 32'h0;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && retire) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (cnt_d == '0) begin
      state_d = RSP_IDLE;
    end else if (cnt_d == MaxCnt) begin
      state_d = RSP_FULL;
    end else begin
      state_d = RSP_BUSY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  // Idle stages carry zero data so rdata/err stay 0 whenever rvalid is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        data_q[i] <= '0;
      end
      cnt_q   <= '0;
      state_q <= RSP_IDLE;
    end else begin
      vld_q[0]  <= accept;
      err_q[0]  <= accept && acc_err;
      data_q[0] <= acc_data;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign instr_rvalid_o = vld_q[ReadLatency-1];
  assign instr_err_o    = err_q[ReadLatency-1];
  assign instr_rdata_o  = data_q[ReadLatency-1];
  assign state_o        = state_q;

endmodule

// File: tb/tb_ristretto_imem_responder.sv
// tb/tb_ristretto_imem_responder.sv - directed bench for ristretto_imem_responder
// Three instances share stimulus: u0 (L=1,M=2), u1 (L=2,M=3), u2 (L=3,M=2).
module tb_ristretto_imem_responder;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [31:0] load_wdata;
  logic [2:0]  gnt, rv, er;
  logic [31:0] rd [3];
  logic [1:0]  st [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ristretto_imem_responder #(.MemWords(64), .ReadLatency(1), .MaxOutstanding(2)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(er[0]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .state_o(st[0]));
  ristretto_imem_responder #(.MemWords(64), .ReadLatency(2), .MaxOutstanding(3)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(er[1]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .state_o(st[1]));
  ristretto_imem_responder #(.MemWords(64), .ReadLatency(3), .MaxOutstanding(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]), .instr_err_o(er[2]),
    .stall_i(stall), .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .state_o(st[2]));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req = 1'b0; addr = '0; stall = 1'b0; load_we = 1'b0;
    cycle();
    cycle();
    rst_ni = 1'b1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    load_we = 1'b1; load_addr = idx[5:0]; load_wdata = v;
    cycle();
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req = 1'b0; stall = 1'b0; load_we = 1'b0; addr = '0;
    load_addr = '0; load_wdata = '0;
    cycle();
    req = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt[k] !== 1'b1 || rv[k] !== 1'b0 || rd[k] !== 32'h0 || er[k] !== 1'b0 || st[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset inst%0d: gnt=%b rv=%b rd=%h err=%b st=%0d, want 1 0 0 0 0",
                 k, gnt[k], rv[k], rd[k], er[k], st[k]);
      end
    end
    req = 1'b0;
    cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic exp_rv;
    logic [31:0] exp_rd;
    do_reset();
    for (int i = 0; i < 8; i++) preload(i, 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 12; c++) begin
      req = (c < 8); addr = 32'(c * 4);
      #1;
      exp_rv = (c >= 2 && c < 10);
      exp_rd = exp_rv ? 32'hA000_0000 + 32'(c - 2) : 32'h0;
      if (c < 8) begin
        checks++;
        if (gnt[1] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gnt cycle %0d: got %b want 1", c, gnt[1]);
        end
      end
      checks++;
      if (rv[1] !== exp_rv || rd[1] !== exp_rd || er[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp cycle %0d: rv=%b rd=%h err=%b want rv=%b rd=%h err=0",
                 c, rv[1], rd[1], er[1], exp_rv, exp_rd);
      end
      cycle();
    end
    checks++;
    if (st[1] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: state=%0d want 0", st[1]);
    end
  endtask

  task automatic test_full_stall();
    int gtab [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    int rtab [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    int stab [10] = '{0, 1, 2, 2, 1, 1, 2, 2, 1, 1};
    int acc = 0;
    int rsp = 0;
    logic [31:0] exp_rd;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req = 1'b1; addr = 32'(acc * 4);
      #1;
      exp_rd = (rtab[c] != 0) ? 32'hA000_0000 + 32'(rsp) : 32'h0;
      checks++;
      if (gnt[2] !== gtab[c][0] || st[2] !== stab[c][1:0]) begin
        errors++;
        $display("FAIL stall_gnt cycle %0d: gnt=%b st=%0d want gnt=%0d st=%0d",
                 c, gnt[2], st[2], gtab[c], stab[c]);
      end
      checks++;
      if (rv[2] !== rtab[c][0] || rd[2] !== exp_rd) begin
        errors++;
        $display("FAIL stall_rsp cycle %0d: rv=%b rd=%h want rv=%0d rd=%h",
                 c, rv[2], rd[2], rtab[c], exp_rd);
      end
      if (gtab[c] != 0) acc++;
      if (rtab[c] != 0) rsp++;
      cycle();
    end
    req = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    preload(5, 32'hDEAD_BEEF);
    req = 1'b1; addr = 32'h14;
    #1;
    checks++;
    if (gnt[0] !== 1'b1 || st[0] !== 2'b00) begin
      errors++;
      $display("FAIL basic_gnt: gnt=%b st=%0d want 1 0", gnt[0], st[0]);
    end
    cycle();
    req = 1'b0;
    #1;
    checks++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'hDEAD_BEEF || er[0] !== 1'b0 || st[0] !== 2'b01) begin
      errors++;
      $display("FAIL basic_rsp: rv=%b rd=%h err=%b st=%0d want 1 deadbeef 0 1", rv[0], rd[0], er[0], st[0]);
    end
    cycle();
    checks++;
    if (rv[0] !== 1'b0 || rd[0] !== 32'h0 || st[0] !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: rv=%b rd=%h st=%0d want 0 0 0", rv[0], rd[0], st[0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] eaddr [2] = '{32'h6, 32'd256};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req = 1'b1; addr = eaddr[k];
      #1;
      checks++;
      if (gnt[0] !== 1'b1 || st[0] !== 2'b00) begin
        errors++;
        $display("FAIL err_gnt %0d: gnt=%b st=%0d want 1 0", k, gnt[0], st[0]);
      end
      cycle();
      req = 1'b0;
      #1;
      checks++;
      if (rv[0] !== 1'b1 || er[0] !== 1'b1 || rd[0] !== 32'h0) begin
        errors++;
        $display("FAIL err_rsp %0d: rv=%b err=%b rd=%h want 1 1 0", k, rv[0], er[0], rd[0]);
      end
      cycle();
    end
    checks++;
    if (st[0] !== 2'b00 || er[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_drain: st=%0d err=%b want 0 0", st[0], er[0]);
    end
  endtask

  task automatic test_collision();
    do_reset();
    preload(3, 32'h1111);
    req = 1'b1; addr = 32'hC;
    load_we = 1'b1; load_addr = 6'd3; load_wdata = 32'h2222;
    #1;
    checks++;
    if (gnt[0] !== 1'b1) begin
      errors++;
      $display("FAIL coll_gnt: got %b want 1", gnt[0]);
    end
    cycle();
    req = 1'b0; load_we = 1'b0;
    #1;
    checks++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'h1111) begin
      errors++;
      $display("FAIL coll_old: rv=%b rd=%h want 1 00001111", rv[0], rd[0]);
    end
    cycle();
    req = 1'b1; addr = 32'hC;
    cycle();
    req = 1'b0;
    #1;
    checks++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'h2222) begin
      errors++;
      $display("FAIL coll_new: rv=%b rd=%h want 1 00002222", rv[0], rd[0]);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      req = 1'b1; addr = 32'(c * 4);
      #1;
      checks++;
      if (gnt[2] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_acc %0d: gnt=%b want 1", c, gnt[2]);
      end
      cycle();
    end
    req = 1'b0; rst_ni = 1'b0;
    cycle();
    rst_ni = 1'b1; req = 1'b1; addr = 32'h8;
    #1;
    checks++;
    if (gnt[2] !== 1'b1 || st[2] !== 2'b00 || rv[2] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: gnt=%b st=%0d rv=%b want 1 0 0", gnt[2], st[2], rv[2]);
    end
    cycle();
    req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rv[2] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_drop %0d: rv=%b want 0", c, rv[2]);
      end
      cycle();
    end
    #1;
    checks++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'hA000_0002) begin
      errors++;
      $display("FAIL rstmid_new: rv=%b rd=%h want 1 a0000002", rv[2], rd[2]);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_basic();
    test_errors();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
